oled_update_ctrl: RTL and testbench

OLED_UPDATE_CTRL -- requirements
Module: oled_update_ctrl

---
 rtl/oled_update_ctrl_pkg.sv | 22 ++
 rtl/oled_update_ctrl_if.sv | 30 +++
 rtl/oled_spi_byte.sv | 50 +++++
 rtl/oled_update_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_oled_update_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/oled_update_ctrl_pkg.sv
// Shared constants and state encoding for the OLED window-update controller.
package oled_update_ctrl_pkg;

  localparam logic [7:0] OP_SET_COL   = 8'h15;
  localparam logic [7:0] OP_SET_ROW   = 8'h75;
  localparam logic [7:0] OP_WRITE_RAM = 8'h5C;

  localparam int BYTE_CLKS     = 16;  // two clk per SPI bit, eight bits
  localparam int RST_HOLD_CLKS = 4;   // panel reset pulse length
  localparam int NUM_REQ       = 2;   // requesters sharing the panel

  typedef enum logic [2:0] {
    RST_HOLD,
    INIT,
    IDLE,
    ARB,
    WIN_CMD,
    PIXELS,
    FINISH
  } state_t;

endpackage

// File: rtl/oled_update_ctrl_if.sv
// Requester-side bus: window requests in, grant/done/pixel fetch out.
interface oled_update_ctrl_if
  import oled_update_ctrl_pkg::*;
#(
  parameter int C_COLOR_BITS = 16,
  parameter int C_X_BITS     = 7,
  parameter int C_Y_BITS     = 7
)();

  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ*4*C_X_BITS-1:0]   req_win;    // per requester {x0,x1,y0,y1}
  logic [NUM_REQ*C_COLOR_BITS-1:0] req_color;
  logic [NUM_REQ-1:0]              grant;
  logic [NUM_REQ-1:0]              done;
  logic                            err;
  logic [C_X_BITS-1:0]             px_x;
  logic [C_Y_BITS-1:0]             px_y;
  logic                            px_strobe;

  modport master (
    output req, req_win, req_color,
    input  grant, done, err, px_x, px_y, px_strobe
  );

  modport slave (
    input  req, req_win, req_color,
    output grant, done, err, px_x, px_y, px_strobe
  );

endinterface

// File: rtl/oled_spi_byte.sv
// Shifts one byte out MSB first over BYTE_CLKS clk; reload on the last
// cycle gives gap-free back-to-back bytes.
module oled_spi_byte
  import oled_update_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       dc,
  output logic       busy,
  output logic       last,
  output logic       spi_clk,
  output logic       spi_mosi,
  output logic       spi_dc
);

  logic [7:0] sh;
  logic [3:0] cnt;
  logic       busy_r;
  logic       dc_r;

  // byte shifter: latch on load, then count through the byte period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh     <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      dc_r   <= 1'b0;
    end else if (load) begin
      sh     <= data;
      cnt    <= '0;
      busy_r <= 1'b1;
      dc_r   <= dc;
    end else if (busy_r) begin
      cnt <= cnt + 1'b1;
      if (cnt == 4'(BYTE_CLKS - 1)) busy_r <= 1'b0;
    end
  end

  // pins: clk low on even counts, bit index 7 - cnt/2; idle clock high
  always_comb begin
    busy     = busy_r;
    last     = busy_r && (cnt == 4'(BYTE_CLKS - 1));
    spi_clk  = busy_r ? cnt[0] : 1'b1;
    spi_mosi = busy_r ? sh[~cnt[3:1]] : 1'b0;
    spi_dc   = dc_r;
  end

endmodule

// File: rtl/oled_update_ctrl.sv
// SSD1351 update controller: panel reset + init stream, then arbitrated
// window writes (column/row/write-RAM commands followed by pixel data).
// The init stream is the packed parameter C_INIT_DATA, first byte in the MSBs.
module oled_update_ctrl
  import oled_update_ctrl_pkg::*;
#(
  parameter int                       C_INIT_SIZE  = 53,
  parameter logic [C_INIT_SIZE*8-1:0] C_INIT_DATA  = {
    8'hFD, 8'h12, 8'hFD, 8'hB1, 8'hAE, 8'hB3, 8'hF1, 8'hCA, 8'h7F, 8'hA2,
    8'h00, 8'hA1, 8'h00, 8'hA0, 8'h74, 8'hB5, 8'h00, 8'hAB, 8'h01, 8'hB4,
    8'hA0, 8'hB5, 8'h55, 8'hC1, 8'hC8, 8'h80, 8'hC8, 8'hC7, 8'h0F, 8'hB1,
    8'h32, 8'hB2, 8'hA4, 8'h00, 8'h00, 8'hBB, 8'h17, 8'hB6, 8'h01, 8'hBE,
    8'h05, 8'hA6, 8'h15, 8'h00, 8'h7F, 8'h75, 8'h00, 8'h7F, 8'hE3, 8'hE3,
    8'hE3, 8'hE3, 8'hAF},
  parameter int                       C_COLOR_BITS = 16,
  parameter int                       C_X_BITS     = 7,
  parameter int                       C_Y_BITS     = 7
)(
  input  logic               clk,
  input  logic               reset,
  oled_update_ctrl_if.slave  bus,
  output logic               spi_csn,
  output logic               spi_clk,
  output logic               spi_mosi,
  output logic               spi_dc,
  output logic               spi_resn
);

  localparam int XB = C_X_BITS;
  localparam int YB = C_Y_BITS;
  localparam int CB = C_COLOR_BITS;
  localparam int WW = 4 * C_X_BITS;
  localparam int IW = $clog2(C_INIT_SIZE + 8);

  state_t          state, nxt;
  logic [1:0]      hold_cnt;
  logic [IW-1:0]   idx;
  logic            ptr, owner, win_sel, win_bad;
  logic            half, last_px, err_r;
  logic [NUM_REQ-1:0] grant_r;
  logic [XB-1:0]   x0_r, x1_r, px_x_r, sx0, sx1;
  logic [YB-1:0]   y0_r, y1_r, px_y_r, sy0, sy1;
  logic [WW-1:0]   sel_win;
  logic [CB-1:0]   own_color;
  logic [7:0]      lsb_r, cmd_nxt, pix_first;
  logic            ld, ld_dc, strobe, arb_fire;
  logic [7:0]      ld_data;
  logic            eng_busy, eng_last;

  function automatic logic [7:0] rom_byte(input int i);
    return C_INIT_DATA[(C_INIT_SIZE - 1 - i) * 8 +: 8];
  endfunction

  // round-robin pick (ptr is the favoured requester) and its window fields
  always_comb begin
    win_sel   = bus.req[ptr] ? ptr : ~ptr;
    sel_win   = win_sel ? bus.req_win[2*WW-1:WW] : bus.req_win[WW-1:0];
    sx0       = sel_win[4*XB-1 -: XB];
    sx1       = sel_win[3*XB-1 -: XB];
    sy0       = sel_win[2*XB-1 -: YB];
    sy1       = sel_win[XB-1 -: YB];
    win_bad   = (sx0 > sx1) || (sy0 > sy1);
    own_color = owner ? bus.req_color[2*CB-1:CB] : bus.req_color[CB-1:0];
    pix_first = 8'(own_color >> (CB - 8));
    arb_fire  = (state == ARB) && (|bus.req);
  end

  // byte following the one at idx in the window command sequence
  always_comb begin
    cmd_nxt = OP_SET_COL;
    case (idx[2:0])
      3'd0:    cmd_nxt = 8'(x0_r);
      3'd1:    cmd_nxt = 8'(x1_r);
      3'd2:    cmd_nxt = OP_SET_ROW;
      3'd3:    cmd_nxt = 8'(y0_r);
      3'd4:    cmd_nxt = 8'(y1_r);
      3'd5:    cmd_nxt = OP_WRITE_RAM;
      default: cmd_nxt = OP_SET_COL;
    endcase
  end

  // next state and byte-engine load decisions
  always_comb begin
    nxt     = state;
    ld      = 1'b0;
    ld_dc   = 1'b0;
    ld_data = 8'h00;
    strobe  = 1'b0;
    case (state)
      RST_HOLD: if (hold_cnt == 2'(RST_HOLD_CLKS - 1)) begin
        nxt     = INIT;
        ld      = 1'b1;
        ld_data = rom_byte(0);
      end
      INIT: if (eng_last) begin
        if (idx == IW'(C_INIT_SIZE - 1)) nxt = IDLE;
        else begin
          ld      = 1'b1;
          ld_data = rom_byte(int'(idx) + 1);
        end
      end
      IDLE: if ((|bus.req) && !eng_busy) nxt = ARB;
      ARB: begin
        if (!(|bus.req))  nxt = IDLE;
        else if (win_bad) nxt = FINISH;
        else begin
          nxt     = WIN_CMD;
          ld      = 1'b1;
          ld_data = OP_SET_COL;
        end
      end
      WIN_CMD: if (eng_last) begin
        ld = 1'b1;
        if (idx[2:0] == 3'd6) begin
          nxt     = PIXELS;
          strobe  = 1'b1;
          ld_dc   = 1'b1;
          ld_data = pix_first;
        end else begin
          ld_data = cmd_nxt;
        end
      end
      PIXELS: if (eng_last) begin
        if ((CB == 16) && !half) begin
          ld      = 1'b1;
          ld_dc   = 1'b1;
          ld_data = lsb_r;
        end else if (last_px) begin
          nxt = FINISH;
        end else begin
          ld      = 1'b1;
          ld_dc   = 1'b1;
          strobe  = 1'b1;
          ld_data = pix_first;
        end
      end
      FINISH:  nxt = IDLE;
      default: nxt = RST_HOLD;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RST_HOLD;
    else       state <= nxt;
  end

  // counters, arbitration, window latch and pixel walker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      idx      <= '0;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      grant_r  <= '0;
      err_r    <= 1'b0;
      x0_r     <= '0;
      x1_r     <= '0;
      y0_r     <= '0;
      y1_r     <= '0;
      px_x_r   <= '0;
      px_y_r   <= '0;
      lsb_r    <= '0;
      half     <= 1'b0;
      last_px  <= 1'b0;
    end else begin
      if (state == RST_HOLD) hold_cnt <= hold_cnt + 1'b1;
      if (state == ARB) idx <= '0;
      else if (ld && (state == INIT || state == WIN_CMD)) idx <= idx + 1'b1;
      if (arb_fire) begin
        owner   <= win_sel;
        grant_r <= win_sel ? 2'b10 : 2'b01;
        ptr     <= ~win_sel;
        err_r   <= win_bad;
        x0_r    <= sx0;
        x1_r    <= sx1;
        y0_r    <= sy0;
        y1_r    <= sy1;
        px_x_r  <= sx0;
        px_y_r  <= sy0;
      end
      if (state == FINISH) grant_r <= '0;
      // coordinates move on as soon as the current pixel is fetched
      if (strobe) begin
        lsb_r   <= own_color[7:0];
        half    <= 1'b0;
        last_px <= (px_x_r == x1_r) && (px_y_r == y1_r);
        if (px_x_r == x1_r) begin
          px_x_r <= x0_r;
          px_y_r <= px_y_r + 1'b1;
        end else begin
          px_x_r <= px_x_r + 1'b1;
        end
      end else if (ld && state == PIXELS) begin
        half <= 1'b1;
      end
    end
  end

  oled_spi_byte u_byte (
    .clk      (clk),
    .reset    (reset),
    .load     (ld),
    .data     (ld_data),
    .dc       (ld_dc),
    .busy     (eng_busy),
    .last     (eng_last),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_dc   (spi_dc)
  );

  // panel control pins and requester-facing outputs
  always_comb begin
    spi_resn      = (state != RST_HOLD);
    spi_csn       = !(state == INIT || state == WIN_CMD || state == PIXELS);
    bus.grant     = grant_r;
    bus.done      = (state == FINISH) ? grant_r : '0;
    bus.err       = (state == FINISH) && err_r;
    bus.px_x      = px_x_r;
    bus.px_y      = px_y_r;
    bus.px_strobe = strobe;
  end

endmodule

// File: tb/tb_oled_update_ctrl.sv
// Directed bench for oled_update_ctrl with a 3-byte init stream {AF,A0,74}.
module tb_oled_update_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spi_csn, spi_clk, spi_mosi, spi_dc, spi_resn;

  oled_update_ctrl_if #(.C_COLOR_BITS(16), .C_X_BITS(7), .C_Y_BITS(7)) bus();

  oled_update_ctrl #(
    .C_INIT_SIZE  (3),
    .C_INIT_DATA  (24'hAFA074),
    .C_COLOR_BITS (16),
    .C_X_BITS     (7),
    .C_Y_BITS     (7)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .spi_csn  (spi_csn),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_dc   (spi_dc),
    .spi_resn (spi_resn)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lows = 0;

  typedef struct { int x; int y; int c; } ev_t;
  ev_t sq[$];
  logic [2:0] dq[$];

  always @(posedge clk) cyc++;

  // event log: pixel fetches, completion pulses, SPI clock low phases
  always @(negedge clk) begin
    if (bus.px_strobe) sq.push_back('{int'(bus.px_x), int'(bus.px_y), cyc});
    if (bus.done != 2'b00) dq.push_back({bus.err, bus.done});
    if (spi_clk === 1'b0) lows++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_win(input int r, input int x0, input int x1, input int y0, input int y1);
    bus.req_win[r*28 +: 28] = {7'(x0), 7'(x1), 7'(y0), 7'(y1)};
  endtask

  // called at the negedge of cycle k=0 of a byte; returns one negedge past it
  task automatic get_byte(output logic [7:0] b, output logic dc0, output logic csn0, output logic ok);
    ok = 1'b1; b = 8'h00; dc0 = spi_dc; csn0 = spi_csn;
    for (int k = 0; k < 16; k++) begin
      if (spi_clk !== k[0]) ok = 1'b0;
      if (!k[0]) b = {b[6:0], spi_mosi};
      @(negedge clk);
    end
  endtask

  task automatic exp_byte(input string tag, input logic [7:0] eb, input logic edc);
    logic [7:0] b; logic dc0, csn0, ok;
    get_byte(b, dc0, csn0, ok);
    check(tag, b, eb);
    check({tag, " dc/csn/clk"}, {dc0, csn0, ok}, {edc, 1'b0, 1'b1});
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!(spi_csn === 1'b0 && spi_clk === 1'b0) && n < 200) begin
      @(negedge clk); n++;
    end
    check({tag, " start timeout"}, n < 200, 1);
  endtask

  task automatic wait_done(input string tag, input int max, output logic [2:0] v);
    int n = 0;
    while (bus.done === 2'b00 && n < max) begin
      @(negedge clk); n++;
    end
    check({tag, " done timeout"}, n < max, 1);
    v = {bus.err, bus.done};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " pins"}, {spi_csn, spi_clk, spi_mosi, spi_dc, spi_resn}, 5'b11000);
    check({tag, " bus"}, {bus.grant, bus.done, bus.err, bus.px_strobe}, 6'b0);
    check({tag, " px"}, {bus.px_x, bus.px_y}, 14'd0);
  endtask

  initial begin
    logic [2:0] v;
    logic [2:0] got [3];
    int lows0, bs, bd, k, n;

    bus.req = 2'b00; bus.req_win = '0; bus.req_color = '0;
    #12;
    check_reset_outputs("reset");

    // panel reset pulse then init stream
    @(negedge clk); reset = 1'b0;
    check("resn hold0", {spi_resn, spi_csn}, 2'b01);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("resn hold", {spi_resn, spi_csn}, 2'b01);
    end
    @(negedge clk);
    check("resn released", spi_resn, 1'b1);
    exp_byte("init0", 8'hAF, 1'b0);
    exp_byte("init1", 8'hA0, 1'b0);
    exp_byte("init2", 8'h74, 1'b0);
    check("init end csn/clk", {spi_csn, spi_clk}, 2'b11);

    // basic window: two pixels of F800
    set_win(0, 2, 3, 5, 5);
    bus.req_color[15:0] = 16'hF800;
    bs = sq.size();
    bus.req = 2'b01;
    wait_start("win");
    check("win grant", bus.grant, 2'b01);
    exp_byte("cmd15", 8'h15, 1'b0);
    exp_byte("cmdx0", 8'h02, 1'b0);
    exp_byte("cmdx1", 8'h03, 1'b0);
    exp_byte("cmd75", 8'h75, 1'b0);
    exp_byte("cmdy0", 8'h05, 1'b0);
    exp_byte("cmdy1", 8'h05, 1'b0);
    exp_byte("cmd5C", 8'h5C, 1'b0);
    exp_byte("pix0 msb", 8'hF8, 1'b1);
    exp_byte("pix0 lsb", 8'h00, 1'b1);
    exp_byte("pix1 msb", 8'hF8, 1'b1);
    exp_byte("pix1 lsb", 8'h00, 1'b1);
    check("win done/err", {bus.err, bus.done}, 3'b001);
    bus.req = 2'b00;
    @(negedge clk);
    check("win done pulse width", {bus.err, bus.done}, 3'b000);
    check("win strobes", sq.size() - bs, 2);
    check("win strobe0 xy", {sq[bs].x[7:0], sq[bs].y[7:0]}, {8'd2, 8'd5});
    check("win strobe1 xy", {sq[bs+1].x[7:0], sq[bs+1].y[7:0]}, {8'd3, 8'd5});

    // round robin after reset, single-pixel windows
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rr reset");
    reset = 1'b0;
    set_win(0, 0, 0, 0, 0);
    set_win(1, 1, 1, 1, 1);
    bus.req_color = {16'hABCD, 16'h1234};
    lows0 = lows; bs = sq.size();
    bus.req = 2'b11;
    k = 0; n = 0;
    while (k < 3 && n < 1500) begin
      @(negedge clk); n++;
      if (bus.done !== 2'b00) begin
        got[k] = {bus.err, bus.done};
        k++;
        if (k == 3) bus.req = 2'b00;
      end
    end
    check("rr timeout", k, 3);
    check("rr grant 1st", got[0], 3'b001);
    check("rr grant 2nd", got[1], 3'b010);
    check("rr grant 3rd", got[2], 3'b001);
    check("rr spi clocks", lows - lows0, 24 + 3 * 9 * 8);
    check("rr strobes", sq.size() - bs, 3);
    check("rr strobe1 xy", {sq[bs+1].x[7:0], sq[bs+1].y[7:0]}, {8'd1, 8'd1});

    // rejected window: no SPI traffic, err with done
    @(negedge clk);
    set_win(1, 9, 4, 0, 0);
    lows0 = lows;
    bus.req = 2'b10;
    wait_done("bad", 20, v);
    check("bad done/err", v, 3'b110);
    check("bad grant", bus.grant, 2'b10);
    check("bad spi clocks", lows - lows0, 0);
    bus.req = 2'b00;
    @(negedge clk);
    check("bad pulse width", {bus.err, bus.done}, 3'b000);

    // 2x2 window, request dropped after grant
    set_win(0, 0, 1, 0, 1);
    bus.req_color[15:0] = 16'h07E0;
    bs = sq.size(); lows0 = lows;
    bus.req = 2'b01;
    n = 0;
    while (bus.grant !== 2'b01 && n < 20) begin
      @(negedge clk); n++;
    end
    check("2x2 grant", bus.grant, 2'b01);
    bus.req = 2'b00;
    wait_done("2x2", 600, v);
    check("2x2 done/err", v, 3'b001);
    check("2x2 strobes", sq.size() - bs, 4);
    check("2x2 spi clocks", lows - lows0, (7 + 8) * 8);
    for (int i = 0; i < 4; i++)
      check($sformatf("2x2 strobe%0d xy", i), {sq[bs+i].x[7:0], sq[bs+i].y[7:0]},
            {8'(i % 2), 8'(i / 2)});
    for (int i = 1; i < 4; i++)
      check($sformatf("2x2 strobe gap%0d", i), sq[bs+i].c - sq[bs+i-1].c, 32);

    // reset in the middle of pixel data
    @(negedge clk);
    set_win(0, 0, 3, 0, 3);
    bus.req = 2'b01;
    n = 0;
    while (bus.px_strobe !== 1'b1 && n < 300) begin
      @(negedge clk); n++;
    end
    check("abort strobe timeout", n < 300, 1);
    repeat (5) @(negedge clk);
    bd = dq.size();
    #2 reset = 1'b1;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    reset = 1'b0;
    bus.req = 2'b00;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("abort resn hold", {spi_resn, spi_csn}, 2'b01);
    end
    @(negedge clk);
    exp_byte("reinit0", 8'hAF, 1'b0);
    exp_byte("reinit1", 8'hA0, 1'b0);
    exp_byte("reinit2", 8'h74, 1'b0);
    check("abort no done", dq.size() - bd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
